// File: rtl/clkdiv_rst_mon.sv
// Reset sequencer and activity monitor for the CLKDIV wrapper. Holds the divider in reset,
// releases it, then counts rising edges of the returned divided clock per window to decide
// whether the divided domain may run (clk_ok) or the divider is dead (clk_fault).
module clkdiv_rst_mon #(
    parameter int unsigned RST_HOLD  = 16,
    parameter int unsigned SETTLE    = 8,
    parameter int unsigned DIV_RATIO = 5,
    parameter int unsigned WIN_LEN   = 64,
    parameter int unsigned EDGE_TOL  = 2,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       hclkin,
    input  logic       resetn,
    input  logic       restart_req,
    input  logic       clkout_mon,
    output logic       div_resetn,
    output logic       clk_ok,
    output logic       clk_fault,
    output logic [3:0] retry_cnt
);

    localparam int unsigned ExpEdges = WIN_LEN / DIV_RATIO;
    localparam int unsigned HsMax    = (RST_HOLD > SETTLE) ? RST_HOLD : SETTLE;
    localparam int unsigned CntMax   = (WIN_LEN > HsMax) ? WIN_LEN : HsMax;
    localparam int unsigned CntW     = $clog2(CntMax);
    localparam int unsigned EdgeW    = $clog2(WIN_LEN + 1);

    localparam logic [CntW-1:0]  HoldLast   = CntW'(RST_HOLD - 1);
    localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE - 1);
    localparam logic [CntW-1:0]  WinLast    = CntW'(WIN_LEN - 1);
    localparam logic [EdgeW-1:0] ExpCnt     = EdgeW'(ExpEdges);
    localparam logic [3:0]       MaxRetry   = 4'(MAX_RETRY);

    typedef enum logic [1:0] {StHold, StSettle, StMonitor, StDead} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cyc_q, cyc_d;
    logic [EdgeW-1:0] edge_q, edge_d;
    logic             s1_q, s2_q, s3_q;
    logic             div_resetn_q, div_resetn_d;
    logic             clk_ok_q, clk_ok_d;
    logic             clk_fault_q, clk_fault_d;
    logic [3:0]       retry_q, retry_d;

    logic             rise;
    logic [EdgeW-1:0] edge_inc;
    logic [EdgeW-1:0] edge_diff;
    logic             win_good;

    // Synchroniser for the divided clock plus one delay flop for rise detection; runs always.
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= clkout_mon;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Window evaluation: include a rise on the evaluation cycle, saturate rather than wrap.
    always_comb begin
        rise      = s2_q & ~s3_q;
        edge_inc  = (rise && (edge_q != '1)) ? edge_q + EdgeW'(1) : edge_q;
        edge_diff = (edge_inc >= ExpCnt) ? edge_inc - ExpCnt : ExpCnt - edge_inc;
        win_good  = (32'(edge_diff) <= EDGE_TOL);
    end

    // Next-state and registered-output logic; restart_req overrides every transition.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q + CntW'(1);
        edge_d   = edge_q;
        clk_ok_d = clk_ok_q;
        retry_d  = retry_q;

        unique case (state_q)
            StHold: begin
                if (cyc_q == HoldLast) begin
                    state_d = StSettle;
                    cyc_d   = '0;
                end
            end
            StSettle: begin
                if (cyc_q == SettleLast) begin
                    state_d = StMonitor;
                    cyc_d   = '0;
                    edge_d  = '0;
                end
            end
            StMonitor: begin
                edge_d = edge_inc;
                if (cyc_q == WinLast) begin
                    cyc_d  = '0;
                    edge_d = '0;
                    if (win_good) begin
                        clk_ok_d = 1'b1;
                    end else begin
                        clk_ok_d = 1'b0;
                        retry_d  = retry_q + 4'd1;
                        state_d  = (retry_d == MaxRetry) ? StDead : StHold;
                    end
                end
            end
            StDead: begin
                cyc_d = '0;
            end
            default: begin
                state_d = StHold;
                cyc_d   = '0;
            end
        endcase

        if (restart_req) begin
            state_d = StHold;
            cyc_d   = '0;
            edge_d  = '0;
            retry_d = '0;
        end

        if (state_d != StMonitor) begin
            clk_ok_d = 1'b0;
        end
        div_resetn_d = (state_d == StSettle) || (state_d == StMonitor);
        clk_fault_d  = (state_d == StDead);
    end

    // State, counters and output registers.
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StHold;
            cyc_q        <= '0;
            edge_q       <= '0;
            div_resetn_q <= 1'b0;
            clk_ok_q     <= 1'b0;
            clk_fault_q  <= 1'b0;
            retry_q      <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            edge_q       <= edge_d;
            div_resetn_q <= div_resetn_d;
            clk_ok_q     <= clk_ok_d;
            clk_fault_q  <= clk_fault_d;
            retry_q      <= retry_d;
        end
    end

    assign div_resetn = div_resetn_q;
    assign clk_ok     = clk_ok_q;
    assign clk_fault  = clk_fault_q;
    assign retry_cnt  = retry_q;

endmodule
